// File: rtl/univ_reg_behv.sv
// N-bit universal register: parallel load, shift, rotate and up/down count,
// with serial output, terminal-count and sticky overflow flags.
module univ_reg_behv #(
  parameter int            N       = 4,
  parameter logic [N-1:0]  RST_VAL = '0,
  parameter bit            SAT     = 1'b0
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] d,
  input  logic         sin,
  input  logic         clr_ovf,
  output logic [N-1:0] q,
  output logic         sout,
  output logic         tc,
  output logic         ovf
);

  localparam logic [N-1:0] ALL_ONES = '1;
  localparam logic [N-1:0] ZERO     = '0;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROTL = 3'b100,
    M_ROTR = 3'b101,
    M_UP   = 3'b110,
    M_DOWN = 3'b111
  } mode_t;

  // Returns {boundary_hit, next_value}; at the boundary the value wraps or pins.
  function automatic logic [N:0] count_up(input logic [N-1:0] v);
    if (v == ALL_ONES)
      return {1'b1, (SAT ? ALL_ONES : ZERO)};
    else
      return {1'b0, v + N'(1)};
  endfunction

  function automatic logic [N:0] count_down(input logic [N-1:0] v);
    if (v == ZERO)
      return {1'b1, (SAT ? ZERO : ALL_ONES)};
    else
      return {1'b0, v - N'(1)};
  endfunction

  logic [N-1:0] q_nxt;
  logic         sout_nxt;
  logic         wrap;
  logic [N:0]   cnt;

  always_comb begin
    q_nxt    = q;
    sout_nxt = sout;
    wrap     = 1'b0;
    cnt      = '0;
    case (mode_t'(mode))
      M_HOLD: q_nxt = q;
      M_LOAD: q_nxt = d;
      M_SHL: begin
        q_nxt    = {q[N-2:0], sin};
        sout_nxt = q[N-1];
      end
      M_SHR: begin
        q_nxt    = {sin, q[N-1:1]};
        sout_nxt = q[0];
      end
      M_ROTL: begin
        q_nxt    = {q[N-2:0], q[N-1]};
        sout_nxt = q[N-1];
      end
      M_ROTR: begin
        q_nxt    = {q[0], q[N-1:1]};
        sout_nxt = q[0];
      end
      M_UP: begin
        cnt   = count_up(q);
        wrap  = cnt[N];
        q_nxt = cnt[N-1:0];
      end
      M_DOWN: begin
        cnt   = count_down(q);
        wrap  = cnt[N];
        q_nxt = cnt[N-1:0];
      end
      default: q_nxt = q;
    endcase
  end

  // Single register stage; a boundary event outranks clr_ovf on the same edge.
  always_ff @(posedge clk) begin
    if (!rest) begin
      q    <= RST_VAL;
      sout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (en) begin
        q    <= q_nxt;
        sout <= sout_nxt;
      end
      if (en && wrap)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  assign tc = ((mode == M_UP) && (q == ALL_ONES)) ||
              ((mode == M_DOWN) && (q == ZERO));

endmodule
